// File: rtl/sonic_dma_irq_scheduler_if.sv
// Host/DMA-side signal bundle for the SoNIC DMA IRQ scheduler.
// master: the side that drives pointers, config and ack (host CSR / DMA engine).
// slave : the scheduler itself.
interface sonic_dma_irq_scheduler_if #(
  parameter int PTR_W = 13
);
  logic             enable;
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [PTR_W-1:0] cfg_thresh;
  logic             irq_ack;
  logic             irq;
  logic [31:0]      data_available;
  logic [31:0]      irq_count;
  logic             range_err;

  modport master (
    output enable, wp, rp, cfg_thresh, irq_ack,
    input  irq, data_available, irq_count, range_err
  );

  modport slave (
    input  enable, wp, rp, cfg_thresh, irq_ack,
    output irq, data_available, irq_count, range_err
  );
endinterface

// File: rtl/sonic_dma_irq_scheduler.sv
// Interrupt-moderation controller for the SoNIC chaining-DMA ring.
// Registers ring occupancy from wp/rp, raises a level IRQ on occupancy
// threshold or coalescing timeout, and enforces a hold-off after each ack.
module sonic_dma_irq_scheduler #(
  parameter int PTR_W       = 13,
  parameter int RING_SIZE   = 8000,
  parameter int TIMEOUT_CYC = 1000,
  parameter int HOLDOFF_CYC = 64
) (
  input  logic                  clk_in,
  input  logic                  rst,
  sonic_dma_irq_scheduler_if.slave bus
);

  localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int HOLD_W = $clog2(HOLDOFF_CYC + 1);

  localparam logic [PTR_W:0]  RING         = RING_SIZE[PTR_W:0];
  localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLDOFF_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FIRE    = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W:0]    occ_q, occ_d;
  logic              range_err_q, range_err_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [31:0]       irq_count_q, irq_count_d;
  logic              irq_q, irq_d;

  logic [PTR_W:0] wp_x, rp_x, occ_calc, thr_eff;
  logic           ptr_bad;

  // Occupancy and range check; an out-of-range pointer freezes occupancy.
  always_comb begin
    wp_x        = {1'b0, bus.wp};
    rp_x        = {1'b0, bus.rp};
    ptr_bad     = (wp_x >= RING) || (rp_x >= RING);
    occ_calc    = (wp_x >= rp_x) ? (wp_x - rp_x) : (wp_x + RING - rp_x);
    occ_d       = ptr_bad ? occ_q : occ_calc;
    range_err_d = range_err_q | ptr_bad;
    thr_eff     = (bus.cfg_thresh == '0) ? {{PTR_W{1'b0}}, 1'b1}
                                         : {1'b0, bus.cfg_thresh};
  end

  // Next-state, timers and IRQ counter; !enable wins over everything.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    hold_d      = hold_q;
    irq_count_d = irq_count_q;
    unique case (state_q)
      IDLE: begin
        if (bus.enable && occ_q != '0) begin
          state_d = COLLECT;
          tmr_d   = '0;
        end
      end
      COLLECT: begin
        tmr_d = tmr_q + 1'b1;
        if (!bus.enable || occ_q == '0) begin
          state_d = IDLE;
        end else if (occ_q >= thr_eff || tmr_q == TMR_LAST) begin
          state_d     = FIRE;
          irq_count_d = irq_count_q + 32'd1;
        end
      end
      FIRE: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end else if (bus.irq_ack) begin
          state_d = HOLDOFF;
          hold_d  = '0;
        end
      end
      HOLDOFF: begin
        hold_d = hold_q + 1'b1;
        if (!bus.enable || hold_q == HOLD_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // irq is a flop mirroring FIRE so the output never glitches on decode
    irq_d = (state_d == FIRE);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      occ_q       <= '0;
      range_err_q <= 1'b0;
      tmr_q       <= '0;
      hold_q      <= '0;
      irq_count_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      range_err_q <= range_err_d;
      tmr_q       <= tmr_d;
      hold_q      <= hold_d;
      irq_count_q <= irq_count_d;
      irq_q       <= irq_d;
    end
  end

  assign bus.irq            = irq_q;
  assign bus.data_available = 32'(occ_q);
  assign bus.irq_count      = irq_count_q;
  assign bus.range_err      = range_err_q;

endmodule

// File: tb/tb_sonic_dma_irq_scheduler.sv
// Scoreboard bench for sonic_dma_irq_scheduler: stimulus pushes expected
// irq edges, occupancy values and status snapshots tagged with a cycle number;
// a negedge monitor pops and compares them as the DUT presents them.
module tb_sonic_dma_irq_scheduler;
  localparam int PTR_W = 13;

  logic clk_in = 1'b0;
  logic rst;
  always #5 clk_in = ~clk_in;

  sonic_dma_irq_scheduler_if #(.PTR_W(PTR_W)) ifc ();

  sonic_dma_irq_scheduler #(
    .PTR_W(PTR_W), .RING_SIZE(8000), .TIMEOUT_CYC(1000), .HOLDOFF_CYC(64)
  ) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .bus   (ifc.slave)
  );

  typedef struct { int cyc; logic lvl; int cnt; } irq_ev_t;
  typedef struct { int cyc; int val; } da_ev_t;
  typedef struct { int cyc; logic re; int cnt; logic irq; } st_ev_t;

  irq_ev_t irq_exp[$];
  da_ev_t  da_exp[$];
  st_ev_t  st_exp[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic prev_irq = 1'b0;
  bit   done = 1'b0;
  bit   flushed = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic void push_irq(int c, logic l, int n);
    irq_exp.push_back('{cyc: c, lvl: l, cnt: n});
  endfunction
  function automatic void push_da(int c, int v);
    da_exp.push_back('{cyc: c, val: v});
  endfunction
  function automatic void push_st(int c, logic re, int n, logic i);
    st_exp.push_back('{cyc: c, re: re, cnt: n, irq: i});
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Monitor: irq edges, occupancy and status compared against the queues.
  always @(negedge clk_in) begin
    irq_ev_t ie;
    da_ev_t  de;
    st_ev_t  se;
    if (ifc.irq !== prev_irq) begin
      n_cmp++;
      if (irq_exp.size() == 0) begin
        n_bad++;
        $display("FAIL irq_edge: got unexpected irq=%0b (count %0d) at cycle %0d, required no edge",
                 ifc.irq, ifc.irq_count, cyc);
      end else begin
        ie = irq_exp.pop_front();
        if (ie.cyc != cyc || ie.lvl !== ifc.irq || ie.cnt != int'(ifc.irq_count)) begin
          n_bad++;
          $display("FAIL irq_edge: got irq=%0b count=%0d at cycle %0d, required irq=%0b count=%0d at cycle %0d",
                   ifc.irq, ifc.irq_count, cyc, ie.lvl, ie.cnt, ie.cyc);
        end
      end
    end
    prev_irq = ifc.irq;
    while (da_exp.size() > 0 && da_exp[0].cyc <= cyc) begin
      de = da_exp.pop_front();
      n_cmp++;
      if (de.cyc != cyc || int'(ifc.data_available) != de.val) begin
        n_bad++;
        $display("FAIL data_available: got %0d at cycle %0d, required %0d at cycle %0d",
                 ifc.data_available, cyc, de.val, de.cyc);
      end
    end
    while (st_exp.size() > 0 && st_exp[0].cyc <= cyc) begin
      se = st_exp.pop_front();
      n_cmp++;
      if (se.cyc != cyc || ifc.range_err !== se.re || int'(ifc.irq_count) != se.cnt ||
          ifc.irq !== se.irq) begin
        n_bad++;
        $display("FAIL status: got range_err=%0b count=%0d irq=%0b at cycle %0d, required %0b/%0d/%0b",
                 ifc.range_err, ifc.irq_count, ifc.irq, cyc, se.re, se.cnt, se.irq);
      end
    end
    if (done && !flushed) begin
      flushed = 1'b1;
      if (irq_exp.size() + da_exp.size() + st_exp.size() != 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pending: got %0d expected events never observed, required 0",
                 irq_exp.size() + da_exp.size() + st_exp.size());
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion by 1ms, required finish");
    $fatal(1, "timeout");
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    int b, a, c, d, e;
    rst = 1'b1;
    ifc.enable = 1'b1;
    ifc.wp = '0;
    ifc.rp = '0;
    ifc.cfg_thresh = 13'd16;
    ifc.irq_ack = 1'b0;
    tick(); tick();
    push_st(cyc + 1, 1'b0, 0, 1'b0);
    push_da(cyc + 1, 0);
    tick();
    rst = 1'b0;

    // Threshold: wp climbs by one per clock, irq two clocks after wp=16
    tick();
    b = cyc;
    push_irq(b + 17, 1'b1, 1);
    for (int i = 1; i <= 20; i++) begin
      ifc.wp = 13'(i);
      push_da(b + i, i);
      tick();
    end

    // Ack and hold-off: irq drops next clk, re-fires 66 clks after ack edge
    tick();
    a = cyc;
    push_irq(a + 1, 1'b0, 1);
    push_irq(a + 67, 1'b1, 2);
    ifc.irq_ack = 1'b1;
    tick();
    ifc.irq_ack = 1'b0;
    repeat (70) tick();

    // Enable drop in FIRE, then re-enable with a stray ack while IDLE
    tick();
    a = cyc;
    push_irq(a + 1, 1'b0, 2);
    push_st(a + 2, 1'b0, 2, 1'b0);
    push_irq(a + 3, 1'b1, 3);
    ifc.enable = 1'b0;
    tick();
    ifc.enable = 1'b1;
    ifc.irq_ack = 1'b1;
    tick();
    ifc.irq_ack = 1'b0;
    repeat (5) tick();

    // Ack out of FIRE and drain the ring to empty
    tick();
    a = cyc;
    push_irq(a + 1, 1'b0, 3);
    push_da(a + 2, 0);
    push_st(a + 70, 1'b0, 3, 1'b0);
    ifc.irq_ack = 1'b1;
    tick();
    ifc.irq_ack = 1'b0;
    ifc.wp = '0;
    repeat (70) tick();

    // Timeout: occupancy 3 below threshold, irq TIMEOUT_CYC after COLLECT entry
    tick();
    b = cyc;
    push_da(b + 1, 3);
    for (int k = 1; k <= 10; k++) push_da(b + 1 + 100 * k, 3);
    push_irq(b + 1002, 1'b1, 4);
    ifc.wp = 13'd3;
    repeat (1005) tick();

    // Wrap: rp=7990, wp=5 gives 15, then rp walks round to wp
    tick();
    a = cyc;
    push_irq(a + 1, 1'b0, 4);
    push_da(a + 1, 15);
    ifc.irq_ack = 1'b1;
    ifc.rp = 13'd7990;
    ifc.wp = 13'd5;
    tick();
    ifc.irq_ack = 1'b0;
    repeat (69) tick();
    c = cyc;
    for (int j = 1; j <= 15; j++) begin
      ifc.rp = 13'((7990 + j) % 8000);
      push_da(c + j, 15 - j);
      tick();
    end
    repeat (5) tick();
    // From IDLE a threshold hit needs IDLE->COLLECT->FIRE: three clocks
    d = cyc;
    push_da(d + 1, 20);
    push_irq(d + 3, 1'b1, 5);
    ifc.wp = 13'd25;
    repeat (5) tick();

    // Range error: occupancy holds, flag sticks after pointer recovers
    tick();
    e = cyc;
    push_da(e + 1, 20);
    push_da(e + 4, 20);
    push_st(e + 2, 1'b1, 5, 1'b1);
    push_da(e + 7, 25);
    push_st(e + 8, 1'b1, 5, 1'b1);
    ifc.wp = 13'd8000;
    repeat (6) tick();
    ifc.wp = 13'd30;
    repeat (4) tick();

    // Asynchronous reset in FIRE clears everything before the next edge
    tick();
    push_irq(cyc, 1'b0, 0);
    push_st(cyc, 1'b0, 0, 1'b0);
    push_da(cyc, 0);
    #1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();

    done = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
